counter_seq_ctrl: RTL and testbench

- Command-driven controller that sequences the free-running wide counter datapath: run/stop, single and multi-step advance, byte-wise preload, and snapshot readout.
- Sits between the top-level pin decoder and the counter register.
- Drives the counter's enable and load controls and serialises the counter value back out as bytes with a valid/ready handshake.

---
 rtl/counter_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for a wide free-running counter datapath.
// Handles run/stop, single and multi-step advance, MSB-first byte preload
// with commit, and a byte-serial snapshot readout with valid/ready.
module counter_seq_ctrl #(
    parameter int WIDTH = 64,
    parameter int BYTES = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_arg,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             busy
);

    localparam int IW = $clog2(BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_STOP   = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_COMMIT = 3'd5;
    localparam logic [2:0] OP_READ   = 3'd6;
    localparam logic [2:0] OP_CLEAR  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_READ = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               run_q, run_d;
    logic               cnt_en_q, cnt_en_d;
    logic               load_q, load_d;
    logic [WIDTH-1:0]   load_val_q, load_val_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   snap_q, snap_d;
    logic [7:0]         rem_q, rem_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               rd_valid_q, rd_valid_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_last_q, rd_last_d;
    logic               busy_q, busy_d;
    logic               accept;

    // Byte i of a value, index 0 being the most significant byte.
    function automatic logic [7:0] byte_at(input logic [WIDTH-1:0] v,
                                           input logic [IW-1:0] i);
        byte_at = v[(BYTES - 1 - int'(i)) * 8 +: 8];
    endfunction

    assign cmd_ready = (state_q == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // Next-state decode: command execution in IDLE, step countdown, readout.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        load_d     = 1'b0;
        load_val_d = load_val_q;
        shreg_d    = shreg_q;
        snap_d     = snap_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_NOP:  ;
                        OP_RUN:  run_d = 1'b1;
                        OP_STOP: run_d = 1'b0;
                        OP_STEP: begin
                            run_d   = 1'b0;
                            rem_d   = cmd_arg;
                            state_d = S_STEP;
                        end
                        OP_LOAD: shreg_d = {shreg_q[WIDTH-9:0], cmd_arg};
                        OP_COMMIT: begin
                            load_val_d = shreg_q;
                            load_d     = 1'b1;
                        end
                        OP_READ: begin
                            snap_d     = cnt_value;
                            idx_d      = '0;
                            state_d    = S_READ;
                            rd_valid_d = 1'b1;
                            rd_data_d  = byte_at(cnt_value, '0);
                            rd_last_d  = 1'b0;
                        end
                        OP_CLEAR: begin
                            shreg_d    = '0;
                            load_val_d = '0;
                            load_d     = 1'b1;
                        end
                    endcase
                end
            end
            S_STEP: begin
                if (rem_q == 8'd0) state_d = S_IDLE;
                else               rem_d   = rem_q - 8'd1;
            end
            S_READ: begin
                if (rd_valid_q && rd_ready) begin
                    if (idx_q == LAST_IDX) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        idx_d     = idx_q + IW'(1);
                        rd_data_d = byte_at(snap_q, idx_q + IW'(1));
                        rd_last_d = ((idx_q + IW'(1)) == LAST_IDX);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        cnt_en_d = run_d | (state_d == S_STEP);
        busy_d   = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any STEP or READ at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            run_q      <= 1'b0;
            cnt_en_q   <= 1'b0;
            load_q     <= 1'b0;
            load_val_q <= '0;
            shreg_q    <= '0;
            snap_q     <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            cnt_en_q   <= cnt_en_d;
            load_q     <= load_d;
            load_val_q <= load_val_d;
            shreg_q    <= shreg_d;
            snap_q     <= snap_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            busy_q     <= busy_d;
        end
    end

    assign cnt_en       = cnt_en_q;
    assign cnt_load     = load_q;
    assign cnt_load_val = load_val_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_last      = rd_last_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural counter datapath.
module tb_counter_seq_ctrl;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [7:0]   cmd_arg = 8'd0;
    logic [W-1:0] cnt;
    logic         cnt_en;
    logic         cnt_load;
    logic [W-1:0] cnt_load_val;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic [7:0]   rd_data;
    logic         rd_last;
    logic         busy;

    int checks = 0;
    int passes = 0;
    int en_cycles = 0;
    int nrdy_cycles = 0;
    int load_pulses = 0;

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cnt_value(cnt), .cnt_en(cnt_en), .cnt_load(cnt_load),
        .cnt_load_val(cnt_load_val),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Counter datapath: load beats increment.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (cnt_load) cnt <= cnt_load_val;
        else if (cnt_en)   cnt <= cnt + 64'd1;
    end

    // Per-cycle activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (cnt_en)     en_cycles++;
        if (!cmd_ready) nrdy_cycles++;
        if (cnt_load)   load_pulses++;
    end

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] arg);
        int waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            $display("FAIL cmd_ready_timeout op=%0d cmd_ready=%b required 1", op, cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({cnt_en, cnt_load, rd_valid, rd_last, busy} !== 5'b0)
            $display("FAIL reset_ctrl got=%b required 00000", {cnt_en, cnt_load, rd_valid, rd_last, busy});
        else passes++;
        checks++; if (cnt_load_val !== 64'd0)
            $display("FAIL reset_load_val got=%h required 0", cnt_load_val);
        else passes++;
        checks++; if (rd_data !== 8'd0)
            $display("FAIL reset_rd_data got=%h required 00", rd_data);
        else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1)
            $display("FAIL reset_cmd_ready got=%b required 1", cmd_ready);
        else passes++;
    endtask

    task automatic test_run_stop();
        logic [W-1:0] c0;
        c0 = cnt;
        en_cycles = 0;
        send_cmd(3'd1, 8'd0);
        repeat (9) @(posedge clk);
        send_cmd(3'd2, 8'd0);
        repeat (3) @(negedge clk);
        checks++; if (en_cycles !== 10)
            $display("FAIL run_en_cycles got=%0d required 10", en_cycles);
        else passes++;
        checks++; if (cnt !== c0 + 64'd10)
            $display("FAIL run_count got=%h required %h", cnt, c0 + 64'd10);
        else passes++;
    endtask

    task automatic test_load();
        for (int i = 1; i <= 8; i++) send_cmd(3'd4, 8'(i));
        load_pulses = 0;
        send_cmd(3'd5, 8'd0);
        repeat (3) @(negedge clk);
        checks++; if (load_pulses !== 1)
            $display("FAIL load_pulses got=%0d required 1", load_pulses);
        else passes++;
        checks++; if (cnt_load_val !== 64'h0102030405060708)
            $display("FAIL load_val got=%h required 0102030405060708", cnt_load_val);
        else passes++;
        checks++; if (cnt !== 64'h0102030405060708)
            $display("FAIL load_counter got=%h required 0102030405060708", cnt);
        else passes++;
    endtask

    task automatic test_step();
        logic [W-1:0] c0;
        c0 = cnt;
        en_cycles = 0;
        nrdy_cycles = 0;
        send_cmd(3'd3, 8'd4);
        repeat (10) @(negedge clk);
        checks++; if (en_cycles !== 5)
            $display("FAIL step4_en_cycles got=%0d required 5", en_cycles);
        else passes++;
        checks++; if (nrdy_cycles !== 5)
            $display("FAIL step4_busy_cycles got=%0d required 5", nrdy_cycles);
        else passes++;
        checks++; if (cnt !== c0 + 64'd5)
            $display("FAIL step4_count got=%h required %h", cnt, c0 + 64'd5);
        else passes++;
        c0 = cnt;
        en_cycles = 0;
        send_cmd(3'd3, 8'd0);
        repeat (4) @(negedge clk);
        checks++; if (en_cycles !== 1)
            $display("FAIL step0_en_cycles got=%0d required 1", en_cycles);
        else passes++;
        checks++; if (cnt !== c0 + 64'd1)
            $display("FAIL step0_count got=%h required %h", cnt, c0 + 64'd1);
        else passes++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 7; i++) send_cmd(3'd4, 8'hFF);
        send_cmd(3'd4, 8'hFE);
        send_cmd(3'd5, 8'd0);
        repeat (2) @(negedge clk);
        checks++; if (cnt !== 64'hFFFFFFFFFFFFFFFE)
            $display("FAIL wrap_preload got=%h required fffffffffffffffe", cnt);
        else passes++;
        send_cmd(3'd3, 8'd2);
        repeat (6) @(negedge clk);
        checks++; if (cnt !== 64'h0000000000000001)
            $display("FAIL wrap_result got=%h required 0000000000000001", cnt);
        else passes++;
    endtask

    task automatic test_read();
        logic [W-1:0] exp_v;
        logic [7:0]   exp_b;
        logic         rdy;
        int           b;
        int           cyc;
        send_cmd(3'd1, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_v     = cnt;
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        cmd_arg   = 8'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rdy = 1'b1;
        b   = 0;
        cyc = 0;
        while (b < 8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            rd_ready = rdy;
            exp_b = exp_v[(7 - b) * 8 +: 8];
            checks++; if (rd_valid !== 1'b1)
                $display("FAIL read_valid byte=%0d got=%b required 1", b, rd_valid);
            else passes++;
            checks++; if (rd_data !== exp_b)
                $display("FAIL read_data byte=%0d got=%h required %h", b, rd_data, exp_b);
            else passes++;
            checks++; if (rd_last !== (b == 7))
                $display("FAIL read_last byte=%0d got=%b required %b", b, rd_last, (b == 7));
            else passes++;
            checks++; if (cmd_ready !== 1'b0)
                $display("FAIL read_cmd_ready byte=%0d got=%b required 0", b, cmd_ready);
            else passes++;
            if (rd_valid && rd_ready) b++;
            rdy = ~rdy;
        end
        @(negedge clk);
        rd_ready = 1'b0;
        checks++; if (b !== 8)
            $display("FAIL read_timeout bytes=%0d required 8", b);
        else passes++;
        checks++; if ({rd_valid, cmd_ready} !== 2'b01)
            $display("FAIL read_end got valid,ready=%b required 01", {rd_valid, cmd_ready});
        else passes++;
        checks++; if (cnt_en !== 1'b1)
            $display("FAIL read_keeps_run got=%b required 1", cnt_en);
        else passes++;
        send_cmd(3'd2, 8'd0);
    endtask

    task automatic test_reset_mid();
        send_cmd(3'd3, 8'd100);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({cnt_en, busy, cmd_ready} !== 3'b001)
            $display("FAIL rst_mid_step got en,busy,ready=%b required 001", {cnt_en, busy, cmd_ready});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        send_cmd(3'd1, 8'd0);
        send_cmd(3'd6, 8'd0);
        repeat (2) @(negedge clk);
        checks++; if (rd_valid !== 1'b1)
            $display("FAIL rst_mid_read_pre got=%b required 1", rd_valid);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if ({rd_valid, cnt_en, busy, cmd_ready} !== 4'b0001)
            $display("FAIL rst_mid_read got valid,en,busy,ready=%b required 0001", {rd_valid, cnt_en, busy, cmd_ready});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({cnt_en, cmd_ready} !== 2'b01)
            $display("FAIL rst_release got en,ready=%b required 01", {cnt_en, cmd_ready});
        else passes++;
    endtask

    initial begin
        test_reset();
        test_run_stop();
        test_load();
        test_step();
        test_wrap();
        test_read();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
